// File: rtl/wb_pkg.sv
// Shared types and sizing for the write-back stage and its result buffer.
package wb_pkg;

    localparam int W     = 8;
    localparam int D     = 4;
    localparam int DEPTH = 4;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [D-1:0] addr;
        logic [W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/writeback_stage_if.sv
// Producer/decode/register-file signal bundle of the write-back stage.
interface writeback_stage_if;
    import wb_pkg::*;

    logic         AluValid;
    logic [D-1:0] AluAddr;
    logic [W-1:0] AluData;
    logic         LoadReq;
    logic [D-1:0] LoadAddr;
    logic [W-1:0] MemData;
    logic [D-1:0] RaddrA;
    logic [D-1:0] RaddrB;
    logic         FwdHitA;
    logic [W-1:0] FwdDataA;
    logic         FwdHitB;
    logic [W-1:0] FwdDataB;
    logic         HazardA;
    logic         HazardB;
    logic         Stall;
    logic         Overflow;
    logic         WriteEn;
    logic [D-1:0] Waddr;
    logic [W-1:0] DataIn;

    modport master (
        output AluValid, AluAddr, AluData,
        output LoadReq, LoadAddr, MemData,
        output RaddrA, RaddrB,
        input  FwdHitA, FwdDataA, FwdHitB, FwdDataB,
        input  HazardA, HazardB, Stall, Overflow,
        input  WriteEn, Waddr, DataIn
    );

    modport slave (
        input  AluValid, AluAddr, AluData,
        input  LoadReq, LoadAddr, MemData,
        input  RaddrA, RaddrB,
        output FwdHitA, FwdDataA, FwdHitB, FwdDataB,
        output HazardA, HazardB, Stall, Overflow,
        output WriteEn, Waddr, DataIn
    );

endinterface

// File: rtl/wb_fifo.sv
// In-order result buffer: two enqueues and one dequeue per cycle,
// with an age-ordered view of every entry for forwarding.
module wb_fifo
    import wb_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push0,
    input  wb_entry_t               ent0,
    input  logic                    push1,
    input  wb_entry_t               ent1,
    output logic                    drop,
    output logic                    head_valid,
    output wb_entry_t               head,
    output logic [CNT_W-1:0]        count,
    output logic [DEPTH-1:0]        view_valid,
    output wb_entry_t [DEPTH-1:0]   view
);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] wr_ptr1;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] free;
    logic             pop;
    logic             acc0;
    logic             acc1;

    assign pop  = (cnt != '0);
    // The slot freed by this cycle's pop is usable by this cycle's pushes.
    assign free = CNT_W'(DEPTH) - cnt + CNT_W'(pop);

    always_comb begin
        acc0 = push0 && (free != '0);
        acc1 = push1 && (free > CNT_W'(acc0));
        drop = (push0 && !acc0) || (push1 && !acc1);
    end

    assign wr_ptr1 = wr_ptr + PTR_W'(acc0);

    always_ff @(posedge clk) begin
        if (acc0) mem[wr_ptr] <= ent0;
        if (acc1) mem[wr_ptr1] <= ent1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            rd_ptr <= rd_ptr + PTR_W'(pop);
            wr_ptr <= wr_ptr1 + PTR_W'(acc1);
            cnt    <= cnt + CNT_W'(acc0) + CNT_W'(acc1)
                      - CNT_W'(pop);
        end
    end

    assign head_valid = pop;
    assign head       = mem[rd_ptr];
    assign count      = cnt;

    always_comb begin
        view_valid = '0;
        view       = '0;
        for (int k = 0; k < DEPTH; k++) begin
            view[k]       = mem[rd_ptr + PTR_W'(k)];
            view_valid[k] = (CNT_W'(k) < cnt);
        end
    end

endmodule

// File: rtl/writeback_stage.sv
// Write-back stage: load tracking, result buffering, register-file
// write port, and forwarding/hazard information for decode.
module writeback_stage
    import wb_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    writeback_stage_if.slave  bus
);

    logic                  load_pend;
    logic [D-1:0]          load_pend_addr;
    logic                  overflow_q;
    logic                  drop;
    logic                  head_valid;
    wb_entry_t             head;
    logic [CNT_W-1:0]      count;
    logic [DEPTH-1:0]      view_valid;
    wb_entry_t [DEPTH-1:0] view;
    wb_entry_t             ent_load;
    wb_entry_t             ent_alu;
    logic [CNT_W:0]        occ;
    logic                  hit_a;
    logic                  hit_b;
    logic [W-1:0]          data_a;
    logic [W-1:0]          data_b;

    assign ent_load = '{addr: load_pend_addr, data: bus.MemData};
    assign ent_alu  = '{addr: bus.AluAddr, data: bus.AluData};

    // Load return is older than a same-cycle ALU result.
    wb_fifo u_fifo (
        .clk        (Clk),
        .rst        (Reset),
        .push0      (load_pend),
        .ent0       (ent_load),
        .push1      (bus.AluValid),
        .ent1       (ent_alu),
        .drop       (drop),
        .head_valid (head_valid),
        .head       (head),
        .count      (count),
        .view_valid (view_valid),
        .view       (view)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            load_pend      <= 1'b0;
            load_pend_addr <= '0;
            overflow_q     <= 1'b0;
        end else begin
            load_pend <= bus.LoadReq;
            if (bus.LoadReq) load_pend_addr <= bus.LoadAddr;
            if (drop) overflow_q <= 1'b1;
        end
    end

    // Ascending age scan so the youngest matching entry wins.
    always_comb begin
        hit_a  = 1'b0;
        hit_b  = 1'b0;
        data_a = '0;
        data_b = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (view_valid[k] && view[k].addr == bus.RaddrA) begin
                hit_a  = 1'b1;
                data_a = view[k].data;
            end
            if (view_valid[k] && view[k].addr == bus.RaddrB) begin
                hit_b  = 1'b1;
                data_b = view[k].data;
            end
        end
    end

    assign occ = {1'b0, count} + (CNT_W+1)'(load_pend);

    assign bus.WriteEn  = head_valid && !Reset;
    assign bus.Waddr    = bus.WriteEn ? head.addr : '0;
    assign bus.DataIn   = bus.WriteEn ? head.data : '0;
    assign bus.FwdHitA  = hit_a && !Reset;
    assign bus.FwdDataA = Reset ? '0 : data_a;
    assign bus.FwdHitB  = hit_b && !Reset;
    assign bus.FwdDataB = Reset ? '0 : data_b;
    assign bus.HazardA  = !Reset && load_pend
                          && (load_pend_addr == bus.RaddrA);
    assign bus.HazardB  = !Reset && load_pend
                          && (load_pend_addr == bus.RaddrB);
    assign bus.Stall    = !Reset
                          && (occ > (CNT_W+1)'(DEPTH - 2));
    assign bus.Overflow = overflow_q && !Reset;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: queue model of buffered writes.
module tb_writeback_stage;
    import wb_pkg::*;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
    } ent_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   stall_seen;

    ent_t       sb[$];
    logic       m_pend;
    logic [3:0] m_pend_addr;
    logic       m_ovf;

    writeback_stage_if bus ();

    writeback_stage dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h @%0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input logic r,
                       input logic av, input logic [3:0] aa,
                       input logic [7:0] ad,
                       input logic lv, input logic [3:0] la,
                       input logic [7:0] md,
                       input logic [3:0] ra, input logic [3:0] rb);
        logic       e_we;
        logic       e_ha;
        logic       e_hb;
        logic [7:0] e_da;
        logic [7:0] e_db;
        logic       e_za;
        logic       e_zb;
        logic       e_st;
        logic       e_ov;
        rst          = r;
        bus.AluValid = av;
        bus.AluAddr  = aa;
        bus.AluData  = ad;
        bus.LoadReq  = lv;
        bus.LoadAddr = la;
        bus.MemData  = md;
        bus.RaddrA   = ra;
        bus.RaddrB   = rb;
        @(negedge clk);
        e_we = 0; e_ha = 0; e_hb = 0; e_da = 0; e_db = 0;
        e_za = 0; e_zb = 0; e_st = 0; e_ov = 0;
        if (!r) begin
            e_we = (sb.size() > 0);
            foreach (sb[i]) begin
                if (sb[i].addr == ra) begin
                    e_ha = 1; e_da = sb[i].data;
                end
                if (sb[i].addr == rb) begin
                    e_hb = 1; e_db = sb[i].data;
                end
            end
            e_za = m_pend && (m_pend_addr == ra);
            e_zb = m_pend && (m_pend_addr == rb);
            e_st = (sb.size() + int'(m_pend)) > DEPTH - 2;
            e_ov = m_ovf;
        end
        if (bus.Stall) stall_seen++;
        chk("WriteEn", 32'(bus.WriteEn), 32'(e_we));
        if (e_we) begin
            chk("Waddr", 32'(bus.Waddr), 32'(sb[0].addr));
            chk("DataIn", 32'(bus.DataIn), 32'(sb[0].data));
        end else if (r) begin
            chk("Waddr_rst", 32'(bus.Waddr), 32'(0));
            chk("DataIn_rst", 32'(bus.DataIn), 32'(0));
        end
        chk("FwdHitA", 32'(bus.FwdHitA), 32'(e_ha));
        chk("FwdDataA", 32'(bus.FwdDataA), 32'(e_da));
        chk("FwdHitB", 32'(bus.FwdHitB), 32'(e_hb));
        chk("FwdDataB", 32'(bus.FwdDataB), 32'(e_db));
        chk("HazardA", 32'(bus.HazardA), 32'(e_za));
        chk("HazardB", 32'(bus.HazardB), 32'(e_zb));
        chk("Stall", 32'(bus.Stall), 32'(e_st));
        chk("Overflow", 32'(bus.Overflow), 32'(e_ov));
        if (r) begin
            sb.delete();
            m_pend = 0;
            m_ovf  = 0;
        end else begin
            if (sb.size() > 0) void'(sb.pop_front());
            if (m_pend) begin
                if (sb.size() < DEPTH) sb.push_back('{m_pend_addr, md});
                else m_ovf = 1;
            end
            if (av) begin
                if (sb.size() < DEPTH) sb.push_back('{aa, ad});
                else m_ovf = 1;
            end
            m_pend = lv;
            if (lv) m_pend_addr = la;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic [3:0] ra);
        for (int i = 0; i < n; i++)
            cyc(0, 0, 0, 0, 0, 0, 8'hEE, ra, 4'hF);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        stall_seen  = 0;
        m_pend      = 0;
        m_pend_addr = 0;
        m_ovf       = 0;

        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1, 0);

        // single ALU write
        cyc(0, 1, 4'd3, 8'h5A, 0, 0, 0, 4'd3, 4'd0);
        idle(3, 4'd3);

        // load path
        cyc(0, 0, 0, 0, 1, 4'd7, 0, 4'd7, 4'd1);
        cyc(0, 0, 0, 0, 0, 0, 8'hC3, 4'd7, 4'd7);
        cyc(0, 0, 0, 0, 0, 0, 8'h00, 4'd7, 4'd2);
        idle(2, 4'd7);

        // load return and ALU to same register
        cyc(0, 0, 0, 0, 1, 4'd2, 0, 4'd2, 4'd0);
        cyc(0, 1, 4'd2, 8'h22, 0, 0, 8'h11, 4'd2, 4'd2);
        cyc(0, 0, 0, 0, 0, 0, 0, 4'd2, 4'd2);
        cyc(0, 0, 0, 0, 0, 0, 0, 4'd2, 4'd2);
        idle(2, 4'd2);

        // fill, ignoring Stall
        for (int i = 0; i < 10; i++)
            cyc(0, 1, 4'($urandom_range(0, 15)), 8'($urandom),
                1, 4'($urandom_range(0, 15)), 8'($urandom),
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        cyc(0, 0, 0, 0, 0, 0, 8'($urandom), 4'd5, 4'd9);
        idle(6, 4'd4);
        chk("ovf_sticky", 32'(bus.Overflow), 32'(1));

        // reset with three entries queued and a load pending
        for (int i = 0; i < 3; i++)
            cyc(0, 1, 4'(i + 8), 8'(i + 8'h40),
                1, 4'(i + 12), 8'(i + 8'h60), 4'(i + 8), 4'd12);
        cyc(1, 0, 0, 0, 0, 0, 8'h77, 4'd8, 4'd14);
        cyc(0, 0, 0, 0, 0, 0, 8'h99, 4'd14, 4'd9);
        idle(3, 4'd14);

        // pointer wrap
        stall_seen = 0;
        for (int i = 0; i < 20; i++)
            cyc(0, 1, 4'(i % 16), 8'((i % 16) + 1), 0, 0, 0,
                4'(i % 16), 4'((i + 15) % 16));
        idle(3, 4'd3);
        chk("wrap_stall", 32'(stall_seen), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
